sobel_window_gen: RTL and testbench
===================================

// Module: sobel_window_gen
// PURPOSE
//  Streaming 3x3 neighbourhood generator; upstream producer for the Sobel edge filter.
//  Takes raster-order 12-bit gray pixels (one per pix_valid) and buffers two previous lines.
//  Emits a registered 3x3 window whose taps map 1:1 onto the filter's data00..data22 inputs.
//  Sits between the gray-conversion stage and the Sobel filter in the camera->VGA path.
// PARAMETERS
//  DATA_W  12   pixel width (gray)
//  IMG_W   320  pixels per line (>=3)
//  IMG_H   240  lines per frame (>=3)
// PORTS
//  clk        in   1       system clock
//  reset      in   1       synchronous, active-high
//  sof        in   1       start of frame; qualified by pix_valid, marks pixel (0,0)
//  pix_valid  in   1       pixel strobe; no backpressure
//  pix_data   in   DATA_W  gray pixel
//  win_valid  out  1       window taps valid this cycle
//  win00..win22  out  DATA_W each  taps; winRC: R = row (0 = oldest line), C = col (0 = oldest col)
//  win_x      out  $clog2(IMG_W)  centre column (only with SOBEL_WIN_COORD_EN)
//  win_y      out  $clog2(IMG_H)  centre row (only with SOBEL_WIN_COORD_EN)
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high.
//  - Reset: win_valid = 0, all taps = 0, x = y = 0, win_x = win_y = 0. Line-buffer contents are don't-care.
//  - Counters x (0..IMG_W-1) and y (0..IMG_H-1) give the position of the accepted pixel.
//    They advance only on pix_valid.
//  - sof & pix_valid: the pixel is (0,0) and the 3x3 tap shift register is cleared.
//    sof mid-frame is legal: it restarts the frame and there is no error.
//  - x == IMG_W-1: x wraps to 0 and y increments.
//    x == IMG_W-1 and y == IMG_H-1: y wraps to 0, so a stream without sof stays frame-aligned.
//  - Line buffers lb1 and lb2, IMG_W x DATA_W each. lb1 holds line y-1; lb2 holds line y-2.
//    Combinational read at address x. On accept: lb2[x] <= lb1[x] and lb1[x] <= pix_data (read-old).
//  - Tap column shift on accept: col0 <= col1, col1 <= col2, col2 <= {lb2[x], lb1[x], pix_data}.
//    Result: win22 = newest pixel (x,y) and win00 = (x-2,y-2).
//  - win_valid asserts 1 cycle after accepting (x,y) with x >= 2 and y >= 2. Centre = (x-1,y-1).
//    Exactly (IMG_W-2)*(IMG_H-2) windows per frame; border centres are never emitted.
//  - pix_valid low: taps, counters and buffers hold; win_valid = 0 next cycle (one pulse per accept).
//  - Reset has priority over sof and pix_valid in the same cycle.
// CONFIGURATION
//  SOBEL_WIN_COORD_EN defined: adds win_x/win_y ports, registered alongside the taps, carrying the centre (x-1,y-1).
//  Not defined: ports absent and no coordinate logic; tap and valid timing identical.
// STRUCTURE
//  - Package sobel_pkg: PIX_W = 12, default IMG_W/IMG_H, typedef pix_t = logic [PIX_W-1:0],
//    typedef win3x3_t (3x3 array of pix_t). Shared with the Sobel filter.
//  - Sub-module sobel_line_buf (one line of storage, read-old, parameterised depth/width),
//    instantiated twice as lb1 and lb2.
// TESTING  (IMG_W=8, IMG_H=6, pixel value = 16*y + x)
//  1. Full frame with sof on the first pixel -> 24 win_valid pulses.
//     First window follows accept of (2,2): win00=0, win11=17, win22=34, win02=2, win20=32.
//  2. Random pix_valid gaps (0-3 idle cycles) -> window sequence identical to test 1; win_valid never high on idle+1 cycles.
//  3. Row wrap: accept (7,2) then (0,3) -> no window after (0,3) or (1,3); next window after (2,3) has win00=16, win22=50.
//  4. sof re-asserted at pixel (5,3) -> no win_valid until the new (2,2); that window again has win00=0, win22=34.
//  5. reset asserted mid-frame after (4,4) -> next cycle win_valid=0 and taps=0; the frame restarts cleanly at the next pixel.
//  6. Macro defined, rerun test 1 -> first window win_x=1, win_y=1; last window win_x=6, win_y=4.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types and defaults for the Sobel edge-detection path
// (window generator and Sobel filter).
package sobel_pkg;

  // Gray pixel width produced by the colour-to-gray stage.
  localparam int PIX_W     = 12;

  // Default frame geometry (QVGA camera path).
  localparam int IMG_W_DEF = 320;
  localparam int IMG_H_DEF = 240;

  typedef logic [PIX_W-1:0] pix_t;

  // 3x3 neighbourhood, indexed [row][col]; row 0 = oldest line, col 0 = oldest column.
  typedef pix_t [2:0][2:0] win3x3_t;

  // Counter/address width for a range of n values, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// One line of pixel storage for the window generator.
// Combinational read at addr, synchronous write at the same addr, so a
// read-modify-write in one cycle returns the old contents (read-old).
module sobel_line_buf
  import sobel_pkg::*;
#(
  parameter int DEPTH = IMG_W_DEF,
  parameter int WIDTH = PIX_W,
  localparam int AW   = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Asynchronous read of the stored pixel for the current column.
  assign rd_data = mem_q[addr];

  // Store the incoming pixel for this column.
  // NOTE: the storage array has no reset; every location is rewritten before a
  // window can use it, and a reset would turn the array into flops instead of RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 neighbourhood generator feeding the Sobel filter.
// Buffers the two previous lines, shifts a 3x3 tap array per accepted pixel
// and flags a window once the newest pixel is at x >= 2 and y >= 2.
// Optional feature: define SOBEL_WIN_COORD_EN to add win_x/win_y (window centre).
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int DATA_W = PIX_W,
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  localparam int X_W   = cnt_w(IMG_W),
  localparam int Y_W   = cnt_w(IMG_H)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sof,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  output logic              win_valid,
  output logic [DATA_W-1:0] win00,
  output logic [DATA_W-1:0] win01,
  output logic [DATA_W-1:0] win02,
  output logic [DATA_W-1:0] win10,
  output logic [DATA_W-1:0] win11,
  output logic [DATA_W-1:0] win12,
  output logic [DATA_W-1:0] win20,
  output logic [DATA_W-1:0] win21,
  output logic [DATA_W-1:0] win22
`ifdef SOBEL_WIN_COORD_EN
  ,
  output logic [X_W-1:0]    win_x,
  output logic [Y_W-1:0]    win_y
`endif
);

  // Tap array indexed [row][col], same layout as win3x3_t but sized by DATA_W.
  typedef logic [2:0][2:0][DATA_W-1:0] taps_t;

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  taps_t          taps_q, taps_d;
  logic           win_valid_q, win_valid_d;

  // Position of the pixel being accepted this cycle (sof forces (0,0)).
  logic [X_W-1:0] cur_x;
  logic [Y_W-1:0] cur_y;
  logic           x_last, y_last;

  logic [DATA_W-1:0] lb1_rd, lb2_rd;
  logic              lb_wr;

  // Resolve the accepted pixel's coordinates and the end-of-line/frame flags.
  always_comb begin
    cur_x  = sof ? '0 : x_q;
    cur_y  = sof ? '0 : y_q;
    x_last = (cur_x == X_W'(IMG_W - 1));
    y_last = (cur_y == Y_W'(IMG_H - 1));
  end

  // Line buffers are written on every accepted pixel; reset wins over the strobe.
  assign lb_wr = pix_valid & ~reset;

  // lb1 holds line y-1 and takes the new pixel.
  sobel_line_buf #(
    .DEPTH (IMG_W),
    .WIDTH (DATA_W)
  ) lb1 (
    .clk     (clk),
    .wr_en   (lb_wr),
    .addr    (cur_x),
    .wr_data (pix_data),
    .rd_data (lb1_rd)
  );

  // lb2 holds line y-2 and takes the pixel lb1 is about to overwrite.
  sobel_line_buf #(
    .DEPTH (IMG_W),
    .WIDTH (DATA_W)
  ) lb2 (
    .clk     (clk),
    .wr_en   (lb_wr),
    .addr    (cur_x),
    .wr_data (lb1_rd),
    .rd_data (lb2_rd)
  );

  // Next-state logic for counters, tap shift register and window strobe.
  // NOTE: every output of this block gets a default before any branch so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    taps_t base;
    x_d         = x_q;
    y_d         = y_q;
    taps_d      = taps_q;
    win_valid_d = 1'b0;
    base        = taps_q;

    if (pix_valid) begin
      // Raster advance with line and frame wrap.
      if (x_last) begin
        x_d = '0;
        y_d = y_last ? '0 : cur_y + Y_W'(1);
      end else begin
        x_d = cur_x + X_W'(1);
        y_d = cur_y;
      end

      // Start of frame discards whatever columns were in flight.
      if (sof) begin
        base = '0;
      end

      for (int r = 0; r < 3; r++) begin
        taps_d[r][0] = base[r][1];
        taps_d[r][1] = base[r][2];
      end
      taps_d[0][2] = lb2_rd;
      taps_d[1][2] = lb1_rd;
      taps_d[2][2] = pix_data;

      // Only interior centres produce a window.
      win_valid_d = (cur_x >= X_W'(2)) && (cur_y >= Y_W'(2));
    end
  end

  // State registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q         <= '0;
      y_q         <= '0;
      taps_q      <= '0;
      win_valid_q <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      taps_q      <= taps_d;
      win_valid_q <= win_valid_d;
    end
  end

`ifdef SOBEL_WIN_COORD_EN
  logic [X_W-1:0] win_x_q, win_x_d;
  logic [Y_W-1:0] win_y_q, win_y_d;

  // Window centre is one column and one row behind the accepted pixel.
  always_comb begin
    win_x_d = win_x_q;
    win_y_d = win_y_q;
    if (pix_valid) begin
      win_x_d = cur_x - X_W'(1);
      win_y_d = cur_y - Y_W'(1);
    end
  end

  // Centre coordinate registers, updated together with the taps.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_x_q <= '0;
      win_y_q <= '0;
    end else begin
      win_x_q <= win_x_d;
      win_y_q <= win_y_d;
    end
  end

  assign win_x = win_x_q;
  assign win_y = win_y_q;
`endif

  assign win_valid = win_valid_q;
  assign win00     = taps_q[0][0];
  assign win01     = taps_q[0][1];
  assign win02     = taps_q[0][2];
  assign win10     = taps_q[1][0];
  assign win11     = taps_q[1][1];
  assign win12     = taps_q[1][2];
  assign win20     = taps_q[2][0];
  assign win21     = taps_q[2][1];
  assign win22     = taps_q[2][2];

endmodule

// File: tb/tb_sobel_window_gen.sv
// Self-checking bench for sobel_window_gen on an 8x6 image.
// Reference model: a frame array indexed by the model's own raster position;
// each window is read straight from the 3x3 block ending at the newest pixel.
module tb_sobel_window_gen;

  localparam int W  = 12;
  localparam int IW = 8;
  localparam int IH = 6;

  logic         clk = 1'b0;
  logic         reset;
  logic         sof;
  logic         pix_valid;
  logic [W-1:0] pix_data;
  logic         win_valid;
  logic [W-1:0] win00, win01, win02, win10, win11, win12, win20, win21, win22;
`ifdef SOBEL_WIN_COORD_EN
  logic [2:0]   win_x;
  logic [2:0]   win_y;
`endif

  sobel_window_gen #(
    .DATA_W (W),
    .IMG_W  (IW),
    .IMG_H  (IH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sof       (sof),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .win_valid (win_valid),
    .win00     (win00),
    .win01     (win01),
    .win02     (win02),
    .win10     (win10),
    .win11     (win11),
    .win12     (win12),
    .win20     (win20),
    .win21     (win21),
    .win22     (win22)
`ifdef SOBEL_WIN_COORD_EN
    ,
    .win_x     (win_x),
    .win_y     (win_y)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [W-1:0] img [IH][IW];
  int mx, my;
  int win_cnt;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [107:0] dut_taps();
    return {win00, win01, win02, win10, win11, win12, win20, win21, win22};
  endfunction

  // 3x3 block whose bottom-right corner is (x,y), oldest row/column first.
  function automatic logic [107:0] model_taps(input int x, input int y);
    logic [107:0] v;
    v = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        v = {v[95:0], img[y-2+r][x-2+c]};
      end
    end
    return v;
  endfunction

  // Accept one pixel and compare the window produced one cycle later.
  task automatic push(input logic s, input logic [W-1:0] d);
    logic exp_v;
    @(negedge clk);
    sof       = s;
    pix_valid = 1'b1;
    pix_data  = d;
    @(posedge clk);
    #1;
    sof       = 1'b0;
    pix_valid = 1'b0;
    if (s) begin
      mx = 0;
      my = 0;
    end
    img[my][mx] = d;
    exp_v = (mx >= 2) && (my >= 2);
    check("win_valid", 128'(win_valid), 128'(exp_v));
    if (exp_v && win_valid) begin
      win_cnt++;
      check("taps", 128'(dut_taps()), 128'(model_taps(mx, my)));
`ifdef SOBEL_WIN_COORD_EN
      check("win_x", 128'(win_x), 128'(mx - 1));
      check("win_y", 128'(win_y), 128'(my - 1));
`endif
    end
    if (mx == IW - 1) begin
      mx = 0;
      my = (my == IH - 1) ? 0 : my + 1;
    end else begin
      mx = mx + 1;
    end
  endtask

  // Idle cycle: nothing accepted, so no window may appear.
  task automatic idle();
    @(posedge clk);
    #1;
    check("idle_valid", 128'(win_valid), 128'(0));
  endtask

  // Synchronous reset with pix_valid and sof also high, to show reset priority.
  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    sof       = 1'b1;
    pix_valid = 1'b1;
    pix_data  = W'($urandom);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    sof       = 1'b0;
    pix_valid = 1'b0;
    mx        = 0;
    my        = 0;
    check("rst_valid", 128'(win_valid), 128'(0));
    check("rst_taps", 128'(dut_taps()), 128'(0));
`ifdef SOBEL_WIN_COORD_EN
    check("rst_win_x", 128'(win_x), 128'(0));
    check("rst_win_y", 128'(win_y), 128'(0));
`endif
  endtask

  // Send the first n pixels of a frame. Pattern data is 16*y+x; the spec's
  // reference windows are checked at (2,2), (2,3) and the last centre.
  task automatic run_frame(input int n, input logic use_sof, input logic rnd, input int max_gap);
    int x, y;
    for (int i = 0; i < n; i++) begin
      x = i % IW;
      y = i / IW;
      for (int g = $urandom_range(0, max_gap); g > 0; g--) idle();
      push(use_sof && (i == 0), rnd ? W'($urandom) : W'(16 * y + x));
      if (!rnd && x == 2 && y == 2) begin
        check("first_win00", 128'(win00), 128'(0));
        check("first_win11", 128'(win11), 128'(17));
        check("first_win22", 128'(win22), 128'(34));
        check("first_win02", 128'(win02), 128'(2));
        check("first_win20", 128'(win20), 128'(32));
`ifdef SOBEL_WIN_COORD_EN
        check("first_win_x", 128'(win_x), 128'(1));
        check("first_win_y", 128'(win_y), 128'(1));
`endif
      end
      if (!rnd && x == 2 && y == 3) begin
        check("wrap_win00", 128'(win00), 128'(16));
        check("wrap_win22", 128'(win22), 128'(50));
      end
`ifdef SOBEL_WIN_COORD_EN
      if (!rnd && x == IW - 1 && y == IH - 1) begin
        check("last_win_x", 128'(win_x), 128'(6));
        check("last_win_y", 128'(win_y), 128'(4));
      end
`endif
    end
  endtask

  initial begin
    reset     = 1'b0;
    sof       = 1'b0;
    pix_valid = 1'b0;
    pix_data  = '0;
    mx        = 0;
    my        = 0;
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++)
        img[r][c] = '0;

    do_reset();

    // Full frame with sof, back-to-back pixels.
    win_cnt = 0;
    run_frame(IW * IH, 1'b1, 1'b0, 0);
    check("frame_windows", 128'(win_cnt), 128'((IW - 2) * (IH - 2)));

    // Same frame with random 0-3 idle cycles between pixels.
    win_cnt = 0;
    run_frame(IW * IH, 1'b1, 1'b0, 3);
    check("gap_windows", 128'(win_cnt), 128'((IW - 2) * (IH - 2)));

    // Frame continuing without sof: wraps from (7,5) back to (0,0).
    win_cnt = 0;
    run_frame(IW * IH, 1'b0, 1'b0, 1);
    check("nosof_windows", 128'(win_cnt), 128'((IW - 2) * (IH - 2)));

    // sof re-asserted where (5,3) would have been.
    run_frame(3 * IW + 5, 1'b1, 1'b0, 0);
    win_cnt = 0;
    run_frame(IW * IH, 1'b1, 1'b0, 0);
    check("resof_windows", 128'(win_cnt), 128'((IW - 2) * (IH - 2)));

    // Reset mid-frame after (4,4); next frame starts at (0,0) without sof.
    run_frame(4 * IW + 5, 1'b1, 1'b0, 0);
    do_reset();
    win_cnt = 0;
    run_frame(IW * IH, 1'b0, 1'b0, 0);
    check("post_rst_windows", 128'(win_cnt), 128'((IW - 2) * (IH - 2)));

    // Random pixel values and random gaps.
    for (int f = 0; f < 3; f++) begin
      win_cnt = 0;
      run_frame(IW * IH, 1'b1, 1'b1, 3);
      check("rand_windows", 128'(win_cnt), 128'((IW - 2) * (IH - 2)));
    end

    idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
